// File: rtl/fifo_flops_prog.sv
// Flop-based FIFO with occupancy count, programmable almost-full/almost-empty,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module fifo_flops_prog #(
    parameter int depth = 8,
    parameter int bits  = 16,
    parameter int fwft  = 0,
    localparam int cnt_w = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [bits-1:0]  Din,
    input  logic             push,
    input  logic             pop,
    output logic [bits-1:0]  Dout,
    output logic             full,
    output logic             pndng,
    output logic [cnt_w-1:0] count,
    input  logic [cnt_w-1:0] af_thresh,
    input  logic [cnt_w-1:0] ae_thresh,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);

    logic [bits-1:0]  mem_q [depth];
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_ok, pop_ok;

    // Status flags decode only the registered count, never the live push/pop.
    assign full         = (count_q == depth_cnt);
    assign pndng        = (count_q != '0);
    assign count        = count_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_comb begin
        pop_ok   = pop && pndng;
        push_ok  = push && (!full || pop_ok);

        rd_ptr_d = rd_ptr_q;
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + 1'b1;
        end

        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event overrides a clear issued in the same cycle.
        ovf_d = clr_err ? 1'b0 : ovf_q;
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
        unf_d = clr_err ? 1'b0 : unf_q;
        if (pop && !pndng) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= Din;
        end
    end

    if (fwft != 0) begin : g_fwft
        assign Dout = pndng ? mem_q[rd_ptr_q] : '0;
    end else begin : g_reg
        logic [bits-1:0] dout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (pop_ok) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end

        assign Dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_flops_prog.sv
// Bench for fifo_flops_prog: registered-read and FWFT instances driven in lockstep,
// checked against a queue-based reference model, a vector table and directed sequences.
module tb_fifo_flops_prog;

    localparam int DEPTH = 8;
    localparam int BITS  = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] Din;
    logic            push, pop, clr_err;
    logic [CW-1:0]   af_t, ae_t;

    logic [BITS-1:0] dout_r, dout_f;
    logic            full_r, full_f, pndng_r, pndng_f;
    logic [CW-1:0]   count_r, count_f;
    logic            af_r, af_f, ae_r, ae_f;
    logic            ovf_r, ovf_f, unf_r, unf_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_flops_prog #(.depth(DEPTH), .bits(BITS), .fwft(0)) u_reg (
        .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop), .Dout(dout_r),
        .full(full_r), .pndng(pndng_r), .count(count_r), .af_thresh(af_t),
        .ae_thresh(ae_t), .almost_full(af_r), .almost_empty(ae_r),
        .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
    );

    fifo_flops_prog #(.depth(DEPTH), .bits(BITS), .fwft(1)) u_ff (
        .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop), .Dout(dout_f),
        .full(full_f), .pndng(pndng_f), .count(count_f), .af_thresh(af_t),
        .ae_thresh(ae_t), .almost_full(af_f), .almost_empty(ae_f),
        .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
    );

    // Reference model: contents as a plain queue, last popped word, sticky flags.
    logic [BITS-1:0] m_q[$];
    logic [BITS-1:0] m_dr;
    bit              m_ovf, m_unf;

    typedef struct {
        logic            push, pop, clr;
        logic [BITS-1:0] din;
        int              cnt;
        logic            full;
        logic [BITS-1:0] dr, df;
        logic            ovf, unf, af, ae;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_dr  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic p, input logic o, input logic c,
                                       input logic [BITS-1:0] d);
        int n   = m_q.size();
        bit pok = o && (n > 0);
        bit puk = p && ((n < DEPTH) || pok);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (o && n == 0) m_unf = 1'b1;
        if (p && !puk)   m_ovf = 1'b1;
        if (pok) m_dr = m_q.pop_front();
        if (puk) m_q.push_back(d);
    endfunction

    task automatic check_model();
        int n = m_q.size();
        chk("count_r", 32'(count_r), 32'(n));
        chk("count_f", 32'(count_f), 32'(n));
        chk("full_r", 32'(full_r), 32'(n == DEPTH));
        chk("full_f", 32'(full_f), 32'(n == DEPTH));
        chk("pndng_r", 32'(pndng_r), 32'(n != 0));
        chk("pndng_f", 32'(pndng_f), 32'(n != 0));
        chk("afull_r", 32'(af_r), 32'(n >= int'(af_t)));
        chk("aempty_f", 32'(ae_f), 32'(n <= int'(ae_t)));
        chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
        chk("unf_f", 32'(unf_f), 32'(m_unf));
        chk("dout_r", 32'(dout_r), 32'(m_dr));
        chk("dout_f", 32'(dout_f), (n != 0) ? 32'(m_q[0]) : 32'h0);
    endtask

    task automatic cycle(input logic p, input logic o, input logic c, input logic [BITS-1:0] d);
        push    = p;
        pop     = o;
        clr_err = c;
        Din     = d;
        @(posedge clk);
        model_step(p, o, c, d);
        #1;
        check_model();
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    // Called from a negedge; reset takes effect without waiting for a clock edge.
    task automatic do_reset();
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b1;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; Din = '0;
        af_t = 4'd6; ae_t = 4'd2;
        model_reset();

        for (int i = 1; i <= 8; i++)
            tbl[i-1] = '{1'b1, 1'b0, 1'b0, 16'(i), i, (i == 8), 16'h0000, 16'h0001,
                         1'b0, 1'b0, (i >= 6), (i <= 2)};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 16'hBEEF, 8, 1'b1, 16'h0000, 16'h0001,
                   1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 16'hCAFE, 8, 1'b1, 16'h0001, 16'h0002,
                   1'b1, 1'b0, 1'b1, 1'b0};
        for (int j = 2; j <= 8; j++)
            tbl[8+j] = '{1'b0, 1'b1, 1'b0, 16'h0000, 9 - j, 1'b0, 16'(j),
                         (j == 8) ? 16'hCAFE : 16'(j + 1), 1'b1, 1'b0,
                         ((9 - j) >= 6), ((9 - j) <= 2)};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 16'hCAFE, 16'h0000,
                    1'b1, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 16'hCAFE, 16'h0000,
                    1'b1, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 16'hCAFE, 16'h0000,
                    1'b0, 1'b1, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 16'hCAFE, 16'h0000,
                    1'b0, 1'b0, 1'b0, 1'b1};

        #2;
        do_reset();
        chk("rst_dout_r", 32'(dout_r), 32'h0);
        chk("rst_ovf_r", 32'(ovf_r), 32'h0);

        for (int k = 0; k < 21; k++) begin
            cycle(tbl[k].push, tbl[k].pop, tbl[k].clr, tbl[k].din);
            chk("tbl_count", 32'(count_r), 32'(tbl[k].cnt));
            chk("tbl_full", 32'(full_r), 32'(tbl[k].full));
            chk("tbl_pndng", 32'(pndng_r), 32'(tbl[k].cnt != 0));
            chk("tbl_dout_r", 32'(dout_r), 32'(tbl[k].dr));
            chk("tbl_dout_f", 32'(dout_f), 32'(tbl[k].df));
            chk("tbl_ovf", 32'(ovf_r), 32'(tbl[k].ovf));
            chk("tbl_unf", 32'(unf_r), 32'(tbl[k].unf));
            chk("tbl_afull", 32'(af_r), 32'(tbl[k].af));
            chk("tbl_aempty", 32'(ae_r), 32'(tbl[k].ae));
        end

        // Pointer wrap: offset both pointers by 5, then fill and drain across the wrap.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 16'(16'h0050 + i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
        chk("wrap_full", 32'(full_r), 32'h1);
        chk("wrap_head_f", 32'(dout_f), 32'h0100);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
            chk("wrap_dout", 32'(dout_r), 32'(16'h0100 + i));
        end
        chk("wrap_empty", 32'(pndng_r), 32'h0);

        // FWFT first word and asynchronous reset while occupied.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 16'h00AA);
        chk("fwft_first", 32'(dout_f), 32'h00AA);
        cycle(1'b1, 1'b0, 1'b0, 16'h00BB);
        cycle(1'b1, 1'b0, 1'b0, 16'h00CC);
        chk("fwft_count3", 32'(count_f), 32'h3);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count_f), 32'h0);
        chk("arst_pndng", 32'(pndng_f), 32'h0);
        chk("arst_dout_f", 32'(dout_f), 32'h0);
        chk("arst_count_r", 32'(count_r), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with alternating fill/drain bias and live threshold changes.
        for (int n = 0; n < 3000; n++) begin
            int bias = ((n / 150) % 2 == 0) ? 75 : 30;
            if (n % 97 == 0) begin
                af_t = 4'($urandom_range(0, 15));
                ae_t = 4'($urandom_range(0, 15));
            end
            cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 5,
                  $urandom_range(0, 39) == 0, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_flops_prog.md
Name: fifo_flops_prog

Overview:
Parametrised successor to the flop-based FIFO. Adds an occupancy count, programmable almost-full and almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through read mode. It drops in wherever the existing FIFO sits between a driver-side producer and a consumer. The existing Din/Dout/push/pop/full/pndng contract is kept as a subset.

Parameters:
depth, 8, number of storage entries; any integer >= 2; not restricted to powers of two.
bits, 16, data word width.
fwft, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
cnt_w, $clog2(depth+1), count and threshold width; localparam, not overridable.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high.
Din  input  bits  write data, sampled on push.
push  input  1  write request.
pop  input  1  read request.
Dout  output  bits  read data.
full  output  1  count == depth.
pndng  output  1  count != 0.
count  output  cnt_w  current occupancy, 0..depth.
af_thresh  input  cnt_w  almost-full threshold.
ae_thresh  input  cnt_w  almost-empty threshold.
almost_full  output  1  count >= af_thresh.
almost_empty  output  1  count <= ae_thresh.
overflow  output  1  sticky flag: push was dropped.
underflow  output  1  sticky flag: pop was ignored.
clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, any time including mid-transfer):
  - Read pointer, write pointer and count go to 0.
  - Dout = 0, overflow = 0, underflow = 0, full = 0, pndng = 0.
  - Storage contents are don't-care.
  - Deassertion is sampled by clk; the first operation is accepted on the first posedge after rst falls.
- Push acceptance (push_ok): push && (!full || pop_ok).
  - A simultaneous pop frees the slot in the same cycle, so push while full with a valid pop is accepted.
- Pop acceptance (pop_ok): pop && pndng.
  - Pop never consumes a word pushed in the same cycle.
  - Push and pop while empty: push accepted, pop ignored, underflow set.
- Pointer and count update:
  - Write pointer advances on push_ok; read pointer advances on pop_ok.
  - Both pointers wrap from depth-1 to 0.
  - count += push_ok - pop_ok, so simultaneous accepted push and pop leave count unchanged.
- Flag derivation:
  - full, pndng, almost_full and almost_empty are combinational decodes of the registered count only; they never depend on the current-cycle push or pop.
  - Threshold inputs are compared live; af_thresh = 0 forces almost_full = 1.
- Dropped operations:
  - Dropped push (push && full && !pop_ok): data discarded, state unchanged, overflow <= 1.
  - Ignored pop (pop && !pndng): state unchanged, Dout unchanged, underflow <= 1.
- Error flags:
  - Flags hold until clr_err or rst.
  - clr_err clears both flags on the next posedge.
  - An error event in the same cycle as clr_err wins: the flag reads 1 afterwards.
- fwft = 0 (registered read):
  - On pop_ok, Dout <= mem[rd_ptr]; the data is valid the cycle after pop.
  - Dout holds its value when there is no pop_ok.
- fwft = 1 (first-word-fall-through):
  - Dout = mem[rd_ptr] combinationally while pndng; Dout = 0 when empty.
  - A pushed word appears on Dout the cycle after push_ok if the FIFO was empty.
  - pop acknowledges the displayed word.
- No combinational path from push or pop to full, pndng or count.

Test Plan:
- Reset, then depth=8, bits=16, fwft=0: push 0x0001..0x0008 on 8 consecutive cycles -> count steps 1..8, full=1 after the 8th edge, then 8 pops return Dout 0x0001..0x0008 in order, each one cycle after its pop, pndng=0 at the end.
- Full FIFO, push 0xBEEF with no pop -> overflow=1, count stays 8, 0xBEEF is never read back; then push 0xCAFE with pop in the same cycle -> count stays 8, 0x0001 is read, 0xCAFE is the last word drained.
- Empty FIFO, pop -> underflow=1, Dout unchanged; clr_err and a second empty pop in the same cycle -> underflow still 1; clr_err alone -> underflow=0 next cycle.
- Thresholds af_thresh=6, ae_thresh=2, push 7 words -> almost_empty is 1 at counts 0..2 and 0 at 3; almost_full is 0 at count 5 and 1 at count 6.
- Wrap-around: 5 pushes, 5 pops, then 8 pushes of 0x0100+i -> full=1, then 8 pops return 0x0100..0x0107 in order with correct pointer wrap.
- fwft=1: push 0x00AA to an empty FIFO -> Dout=0x00AA the next cycle with no pop; assert rst while count=3 -> count=0, pndng=0, Dout=0 immediately, without waiting for a clk edge.
